fetch_controller: RTL

Sequencer for the instruction-fetch path. It owns the program counter and issues word reads to instruction memory over the syn/ack handshake. It delivers each returned instruction with its PC to decode through a one-entry output register that honours decode stall. It also handles branch/jump redirect (flush), end-of-program (last) detection and an ack timeout.

---
 rtl/fetch_controller_pkg.sv | 15 +
 rtl/fetch_watchdog.sv | 42 ++++
 rtl/fetch_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction-fetch path: sequencer state
// encodings and the PC step between consecutive instruction words.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_REQ  = 2'd1,
    FC_DONE = 2'd2,
    FC_ERR  = 2'd3
  } fc_state_e;

  // Byte distance between consecutive 32-bit instruction words.
  localparam int unsigned FC_PC_INCR = 4;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive cycles a memory request waits without ack and flags
// expiry in the cycle where the count reaches TIMEOUT, so the request is
// never held for more than TIMEOUT cycles.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count waiting cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // This waiting cycle is the TIMEOUT-th one.
  assign expired = run & ~clear & (cnt_q == LIMIT);

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues word reads over the
// syn/ack handshake and presents each returned word with its PC to decode
// through a one-entry output register.
//
// Handshakes:
//   memory side: fc_o_syn is a request; a word transfers in a cycle where
//     fc_o_syn & fc_i_ack. fc_i_ack/fc_i_instr/fc_i_last mean nothing while
//     fc_o_syn is low, and syn may drop without ack (cancel).
//   decode side: fc_o_ce marks fc_o_instr/fc_o_pc valid; the item is taken
//     in a cycle where fc_o_ce & ~fc_i_stall.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned           IWIDTH   = 32,
  parameter int unsigned           PC_WIDTH = 32,
  parameter int unsigned           DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
  parameter int unsigned           TIMEOUT  = 15
) (
  input  logic                fc_clk,
  input  logic                fc_rst,
  input  logic                fc_i_ce,
  input  logic                fc_i_stall,
  input  logic                fc_i_flush,
  input  logic [PC_WIDTH-1:0] fc_i_target,
  output logic                fc_o_syn,
  output logic [DEPTH-1:0]    fc_o_addr,
  input  logic                fc_i_ack,
  input  logic [IWIDTH-1:0]   fc_i_instr,
  input  logic                fc_i_last,
  output logic [IWIDTH-1:0]   fc_o_instr,
  output logic [PC_WIDTH-1:0] fc_o_pc,
  output logic                fc_o_ce,
  output logic                fc_o_done,
  output logic                fc_o_err,
  output logic [1:0]          fc_o_dbg_state
);

  fc_state_e state_q, state_d;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IWIDTH-1:0]   out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                out_ce_q, out_ce_d;

  logic                blk;
  logic                syn;
  logic                acc;
  logic                wd_run;
  logic                wd_clear;
  logic                wd_expired;
  logic [PC_WIDTH-1:0] flush_pc;
  logic [PC_WIDTH-1:0] pc_inc;

  // Redirect targets are word aligned; the low bits carry no information.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^fc_i_target[1:0];

  // Handshake qualification: a full, stalled output register or a redirect
  // in progress keeps the request low so nothing can be accepted.
  always_comb begin
    blk      = out_ce_q & fc_i_stall;
    syn      = (state_q == FC_REQ) & fc_i_ce & ~blk & ~fc_i_flush;
    acc      = syn & fc_i_ack;
    wd_run   = syn & ~fc_i_ack;
    wd_clear = acc | ~syn | fc_i_flush;
    flush_pc = {fc_i_target[PC_WIDTH-1:2], 2'b00};
    pc_inc   = pc_q + PC_WIDTH'(FC_PC_INCR);
  end

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (fc_clk),
    .rst_n   (fc_rst),
    .run     (wd_run),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  // Next-state logic; a redirect overrides every state.
  always_comb begin
    state_d = state_q;
    if (fc_i_flush) begin
      state_d = fc_i_ce ? FC_REQ : FC_IDLE;
    end else begin
      case (state_q)
        FC_IDLE: begin
          if (fc_i_ce) begin
            state_d = FC_REQ;
          end
        end
        FC_REQ: begin
          if (acc) begin
            state_d = fc_i_last ? FC_DONE : FC_REQ;
          end else if (wd_expired) begin
            state_d = FC_ERR;
          end else if (!fc_i_ce) begin
            state_d = FC_IDLE;
          end
        end
        FC_DONE: state_d = FC_DONE;
        FC_ERR:  state_d = FC_ERR;
        default: state_d = FC_IDLE;
      endcase
    end
  end

  // PC and output register updates: redirect drops the pending item and any
  // same-cycle data, an accepted word replaces the register (even while the
  // old item is being consumed), otherwise a consumed item just empties it.
  always_comb begin
    pc_d        = pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_ce_d    = out_ce_q;
    if (fc_i_flush) begin
      pc_d     = flush_pc;
      out_ce_d = 1'b0;
    end else if (acc) begin
      pc_d        = pc_inc;
      out_instr_d = fc_i_instr;
      out_pc_d    = pc_q;
      out_ce_d    = 1'b1;
    end else if (out_ce_q && !fc_i_stall) begin
      out_ce_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge fc_clk) begin
    if (!fc_rst) begin
      state_q     <= FC_IDLE;
      pc_q        <= RESET_PC;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_ce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_ce_q    <= out_ce_d;
    end
  end

  assign fc_o_syn       = syn;
  assign fc_o_addr      = pc_q[DEPTH+1:2];
  assign fc_o_instr     = out_instr_q;
  assign fc_o_pc        = out_pc_q;
  assign fc_o_ce        = out_ce_q;
  assign fc_o_done      = (state_q == FC_DONE);
  assign fc_o_err       = (state_q == FC_ERR);
  assign fc_o_dbg_state = state_q;

endmodule
